// File: rtl/spi_display_pkg.sv
// Shared definitions for the SPI display receiver: register map, FSM states, word width.
package spi_display_pkg;

  localparam int WORD_BITS = 16;
  localparam logic [4:0] BIT_CNT_MAX = 5'd17;

  localparam logic [3:0] NOOP      = 4'h0;
  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DIGIT6    = 4'h7;
  localparam logic [3:0] DIGIT7    = 4'h8;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCANLIM   = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_display_receiver_code_b_decoder.sv
// Combinational MAX7219 Code-B font: 4-bit code plus DP to segments {DP,A,B,C,D,E,F,G}.
module code_b_decoder
  import spi_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph = 7'h00;
    case (code)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h01;
      4'hB: glyph = 7'h4F;
      4'hC: glyph = 7'h37;
      4'hD: glyph = 7'h0E;
      4'hE: glyph = 7'h67;
      default: glyph = 7'h00;
    endcase
  end

  assign seg = {dp, glyph};

endmodule

// File: rtl/spi_display_receiver.sv
// SPI slave that decodes 16-bit MAX7219-style writes into a display register file.
// Define SPI_RX_CODEB_EN to compile in the Code-B digit decoder.
module spi_display_receiver
  import spi_display_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [2:0] digit_sel,
  output logic [7:0] digit_seg,
  output logic       word_valid,
  output logic [3:0] word_addr,
  output logic [7:0] word_data,
  output logic       frame_err,
  output logic       display_on,
  output logic [7:0] decode_mode
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_prev;
  logic                   cs_prev;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   settled;
  logic                   armed;
  logic                   sck_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  rx_state_t              state;
  rx_state_t              next_state;
  logic                   start_frame;
  logic                   shift_en;
  logic                   commit;
  logic                   reject;

  logic [WORD_BITS-1:0]   shift_reg;
  logic [4:0]             bit_cnt;
  logic [3:0]             addr;
  logic [7:0]             data;

  logic [7:0]             digit_reg [8];
  logic [7:0]             decode_reg;
  logic [3:0]             intensity;
  logic [2:0]             scan_limit;
  logic                   shutdown_reg;
  logic                   test_reg;

  logic [7:0]             sel_digit;
  logic [7:0]             decoded_seg;
  logic                   use_decode;
  logic                   unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A frame already in flight when reset releases is ignored until CS is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev   <= 1'b0;
      cs_prev    <= 1'b1;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
      armed <= armed | (settled & cs_s);
    end
  end

  assign settled  = (settle_cnt == SETTLE_W'(SYNC_STAGES));
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_fall  = armed & cs_prev & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = SHIFT;
      SHIFT:   if (cs_rise) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    reject      = 1'b0;
    case (state)
      IDLE:  start_frame = cs_fall;
      SHIFT: shift_en    = sck_rise;
      CHECK: begin
        commit = (bit_cnt == 5'(WORD_BITS));
        reject = (bit_cnt != 5'(WORD_BITS));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (start_frame) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_s};
      if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign addr = shift_reg[11:8];
  assign data = shift_reg[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_reg[i] <= 8'h00;
      decode_reg   <= 8'h00;
      intensity    <= 4'h0;
      scan_limit   <= 3'd0;
      shutdown_reg <= 1'b0;
      test_reg     <= 1'b0;
      word_addr    <= 4'h0;
      word_data    <= 8'h00;
      word_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      word_valid <= commit;
      frame_err  <= reject;
      if (commit) begin
        word_addr <= addr;
        word_data <= data;
        case (addr)
          DIGIT0, DIGIT1, DIGIT2, DIGIT3,
          DIGIT4, DIGIT5, DIGIT6, DIGIT7: digit_reg[3'(addr - 4'd1)] <= data;
          DECODE:    decode_reg   <= data;
          INTENSITY: intensity    <= data[3:0];
          SCANLIM:   scan_limit   <= data[2:0];
          SHUTDOWN:  shutdown_reg <= data[0];
          TEST:      test_reg     <= data[0];
          NOOP:      ;
          default:   ;
        endcase
      end
    end
  end

  assign display_on  = shutdown_reg;
  assign decode_mode = decode_reg;
  assign sel_digit   = digit_reg[digit_sel];

`ifdef SPI_RX_CODEB_EN
  code_b_decoder u_code_b_decoder (
    .code (sel_digit[3:0]),
    .dp   (sel_digit[7]),
    .seg  (decoded_seg)
  );
  assign use_decode = decode_reg[digit_sel];
`else
  assign decoded_seg = sel_digit;
  assign use_decode  = 1'b0;
`endif

  always_comb begin
    digit_seg = sel_digit;
    if (test_reg)                    digit_seg = 8'hFF;
    else if (!shutdown_reg)          digit_seg = 8'h00;
    else if (digit_sel > scan_limit) digit_seg = 8'h00;
    else if (use_decode)             digit_seg = decoded_seg;
  end

  // Intensity and the top address nibble are held but have no consumer on this tile.
  assign unused_bits = ^{shift_reg[15:12], intensity};

endmodule
